// File: rtl/dma_rd_port.sv
// Read-side DMA port: engine half-word requests to single-word MCB reads,
// with a one-line read cache for adjacent half-words.
module dma_rd_port #(
  parameter int ADDR_W   = 30,
  parameter int TIMEOUT  = 1023,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reads_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              invalidate,
  output logic [15:0]       ob_data,
  output logic              ob_we,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic              cmd_full,
  output logic              rd_en,
  input  logic [31:0]       rd_data,
  input  logic              rd_empty,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, GAP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lat_q, lat_d;
  logic [31:0]       line_q, line_d;
  logic [ADDR_W-2:0] tag_q, tag_d;
  logic              valid_q, valid_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       ob_data_d;
  logic              ob_we_d;
  logic              cmd_en_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic              rd_en_d;
  logic              busy_d;
  logic              err_d;
  logic              hit;

  assign cmd_instr = 3'b001;
  assign cmd_bl    = 6'd0;

  // A same-cycle invalidate always beats a lookup
  assign hit = CACHE_EN && valid_q && !invalidate &&
               (tag_q == addr[ADDR_W-1:1]);

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    line_d     = line_q;
    tag_d      = tag_q;
    valid_d    = valid_q & ~invalidate;
    timer_d    = '0;
    ob_data_d  = ob_data;
    ob_we_d    = 1'b0;
    cmd_en_d   = 1'b0;
    cmd_addr_d = cmd_byte_addr;
    rd_en_d    = 1'b0;
    err_d      = err;
    unique case (state_q)
      IDLE: begin
        if (reads_en) begin
          if (hit) begin
            ob_we_d   = 1'b1;
            ob_data_d = addr[0] ? line_q[31:16] : line_q[15:0];
            state_d   = GAP;
          end else begin
            lat_d   = addr;
            state_d = CMD;
          end
        end else if (!rd_empty && !rd_en) begin
          // orphaned word from an aborted transaction
          rd_en_d = 1'b1;
        end
      end
      CMD: begin
        if (!cmd_full) begin
          cmd_en_d   = 1'b1;
          cmd_addr_d = {lat_q[ADDR_W-2:1], 2'b00};
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!rd_empty && !rd_en) begin
          rd_en_d   = 1'b1;
          line_d    = rd_data;
          tag_d     = lat_q[ADDR_W-1:1];
          valid_d   = CACHE_EN;
          ob_data_d = lat_q[0] ? rd_data[31:16] : rd_data[15:0];
          ob_we_d   = reads_en;
          state_d   = GAP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          ob_data_d = 16'h0;
          ob_we_d   = 1'b1;
          valid_d   = 1'b0;
          state_d   = GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      line_q        <= '0;
      tag_q         <= '0;
      valid_q       <= 1'b0;
      timer_q       <= '0;
      ob_data       <= '0;
      ob_we         <= 1'b0;
      cmd_en        <= 1'b0;
      cmd_byte_addr <= '0;
      rd_en         <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      line_q        <= line_d;
      tag_q         <= tag_d;
      valid_q       <= valid_d;
      timer_q       <= timer_d;
      ob_data       <= ob_data_d;
      ob_we         <= ob_we_d;
      cmd_en        <= cmd_en_d;
      cmd_byte_addr <= cmd_addr_d;
      rd_en         <= rd_en_d;
      busy          <= busy_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_rd_port.sv
// Directed bench for dma_rd_port: MCB model with FWFT read FIFO,
// engine scoreboard of expected half-words.
module tb_dma_rd_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reads_en = 1'b0;
  logic [29:0] addr = '0;
  logic        invalidate = 1'b0;
  logic [15:0] ob_data;
  logic        ob_we;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full = 1'b0;
  logic        rd_en;
  logic [31:0] rd_data = '0;
  logic        rd_empty = 1'b1;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  dma_rd_port dut (
    .clk(clk), .rst(rst), .reads_en(reads_en), .addr(addr),
    .invalidate(invalidate), .ob_data(ob_data), .ob_we(ob_we),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int lat = 2;
  int gen = 0;
  bit mute = 1'b0;
  int cmd_cnt = 0;
  int rd_cnt = 0;
  int we_cnt = 0;
  logic [29:0] last_cmd_addr = '0;
  logic [31:0] fifo[$];
  int          pend_t[$];
  logic [31:0] pend_d[$];
  logic [15:0] exp_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [29:0] a, int g);
    logic [31:0] w;
    if (a == 30'h20000 && g == 0) w = 32'h3413_3a07;
    else w = ({2'b00, a} * 32'h9E37_79B1) ^ (g * 32'h5BD1_E995) ^ 32'h0F0F_1234;
    return w;
  endfunction

  function automatic logic [15:0] model_half(logic [29:0] a);
    logic [31:0] w;
    w = mem_word({a[28:1], 2'b00}, gen);
    return a[0] ? w[31:16] : w[15:0];
  endfunction

  // MCB model: commands complete after lat cycles into an FWFT FIFO
  always @(posedge clk) begin
    cyc++;
    if (rd_en) begin
      rd_cnt++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    if (cmd_en) begin
      cmd_cnt++;
      last_cmd_addr = cmd_byte_addr;
      if (!mute) begin
        pend_t.push_back(cyc + lat);
        pend_d.push_back(mem_word(cmd_byte_addr, gen));
      end
    end
    while (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      void'(pend_t.pop_front());
      fifo.push_back(pend_d.pop_front());
    end
    rd_empty <= (fifo.size() == 0);
    rd_data  <= (fifo.size() > 0) ? fifo[0] : 32'h0;
  end

  // Engine-side scoreboard
  always @(negedge clk) begin
    if (ob_we) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("unexpected_we", {31'b0, ob_we}, 32'h0);
      else chk("ob_data", {16'h0, ob_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic wait_we(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ob_we && n < 2000);
    if (!ob_we) chk("we_timeout", {31'b0, ob_we}, 32'h1);
  endtask

  task automatic req(input logic [29:0] a, input bit cont, output int n);
    addr = a;
    reads_en = 1'b1;
    exp_q.push_back(model_half(a));
    wait_we(n);
    if (!cont) reads_en = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  int n, c0, r0, w0;

  initial begin
    idle(3);
    chk("rst_ob_we", {31'b0, ob_we}, 32'h0);
    chk("rst_ob_data", {16'h0, ob_data}, 32'h0);
    chk("rst_cmd_en", {31'b0, cmd_en}, 32'h0);
    chk("rst_rd_en", {31'b0, rd_en}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("cmd_instr", {29'b0, cmd_instr}, 32'h1);
    chk("cmd_bl", {26'b0, cmd_bl}, 32'h0);
    rst = 1'b0;
    idle(2);

    // 1: miss with 2-cycle MCB latency
    c0 = cmd_cnt; r0 = rd_cnt; w0 = we_cnt;
    req(30'h10000, 1'b1, n);
    chk("t1_data", {16'h0, ob_data}, 32'h3a07);
    chk("t1_cmd_addr", {2'b0, last_cmd_addr}, 32'h20000);
    // 2: adjacent half is a hit, two edges after the request
    req(30'h10001, 1'b1, n);
    chk("t2_hit_edges", n, 2);
    chk("t2_data", {16'h0, ob_data}, 32'h3413);
    chk("t12_cmds", cmd_cnt - c0, 1);
    chk("t12_pops", rd_cnt - r0, 1);
    req(30'h10002, 1'b0, n);
    idle(3);
    chk("t2_miss_cmds", cmd_cnt - c0, 2);
    chk("t12_we", we_cnt - w0, 3);

    // 3: command backpressure
    c0 = cmd_cnt;
    cmd_full = 1'b1;
    addr = 30'h12345;
    reads_en = 1'b1;
    exp_q.push_back(model_half(30'h12345));
    idle(5);
    chk("t3_held", cmd_cnt - c0, 0);
    chk("t3_busy", {31'b0, busy}, 32'h1);
    cmd_full = 1'b0;
    wait_we(n);
    reads_en = 1'b0;
    idle(3);
    chk("t3_one_cmd", cmd_cnt - c0, 1);

    // 4: invalidate coincident with a would-be hit
    req(30'h10000, 1'b0, n);
    idle(3);
    gen = 1;
    c0 = cmd_cnt;
    addr = 30'h10001;
    reads_en = 1'b1;
    invalidate = 1'b1;
    exp_q.push_back(model_half(30'h10001));
    @(posedge clk); #1;
    invalidate = 1'b0;
    wait_we(n);
    reads_en = 1'b0;
    chk("t4_fresh", {16'h0, ob_data}, {16'h0, model_half(30'h10001)});
    chk("t4_cmd", cmd_cnt - c0, 1);
    idle(3);

    // 5: read timeout
    mute = 1'b1;
    c0 = cmd_cnt; w0 = we_cnt;
    addr = 30'h2000;
    reads_en = 1'b1;
    exp_q.push_back(16'h0);
    wait_we(n);
    reads_en = 1'b0;
    chk("t5_edges", n, 1025);
    chk("t5_err", {31'b0, err}, 32'h1);
    chk("t5_data", {16'h0, ob_data}, 32'h0);
    idle(3);
    chk("t5_one_we", we_cnt - w0, 1);
    mute = 1'b0;
    req(30'h3001, 1'b0, n);
    idle(3);
    chk("t5_recover", {16'h0, ob_data}, {16'h0, model_half(30'h3001)});
    chk("t5_err_sticky", {31'b0, err}, 32'h1);

    // 6: reset during WAIT, late word drained
    lat = 6;
    c0 = cmd_cnt; r0 = rd_cnt; w0 = we_cnt;
    addr = 30'h4000;
    reads_en = 1'b1;
    n = 0;
    while (cmd_cnt == c0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_cmd_seen", cmd_cnt - c0, 1);
    idle(1);
    rst = 1'b1;
    reads_en = 1'b0;
    idle(1);
    chk("t6_rst_busy", {31'b0, busy}, 32'h0);
    chk("t6_rst_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    idle(12);
    chk("t6_drained", {31'b0, rd_empty}, 32'h1);
    chk("t6_pops", rd_cnt - r0, 1);
    chk("t6_no_we", we_cnt - w0, 0);
    c0 = cmd_cnt;
    req(30'h4001, 1'b0, n);
    idle(2);
    chk("t6_cold_miss", cmd_cnt - c0, 1);

    // continuous stream over 45 half-words
    c0 = cmd_cnt; w0 = we_cnt;
    for (int i = 0; i < 45; i++) begin
      lat = int'($urandom_range(1, 4));
      req(30'h5000 + 30'(i), 1'b1, n);
    end
    reads_en = 1'b0;
    idle(4);
    chk("stream_we", we_cnt - w0, 45);
    chk("stream_cmds", cmd_cnt - c0, 23);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
